// File: rtl/uart_rx_axis_master.sv
// 8N1 UART receiver that packs four bytes (first byte in [7:0]) into one
// 32-bit AXI4-Stream beat held in a single-word output buffer.
module uart_rx_axis_master #(
  parameter int DIV = 868,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESETN,
  input  logic                            rxd,
  output logic                            M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  input  logic                            M_AXIS_TREADY,
  output logic                            frame_err,
  output logic                            overrun,
  output logic [1:0]                      dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [9:0] DIV_M1  = 10'(DIV - 1);
  localparam logic [9:0] HALF_M1 = 10'(DIV / 2 - 1);

  logic                            rx_meta_q;
  logic                            rxs_q;
  logic                            rxs_prev_q;
  logic [1:0]                      state_q, state_d;
  logic [9:0]                      cnt_q, cnt_d;
  logic [2:0]                      bit_q, bit_d;
  logic [7:0]                      shift_q, shift_d;
  logic [1:0]                      idx_q, idx_d;
  logic [23:0]                     pack_q, pack_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                            tvalid_q, tvalid_d;
  logic                            ferr_q, ferr_d;
  logic                            ovr_q, ovr_d;
  logic                            word_done;

  // Stream port: a beat transfers on a rising edge where TVALID and TREADY are
  // both high. TVALID comes straight from a flop, and TDATA only changes when
  // the buffer is empty or is being emptied in that same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 10'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    pack_d    = pack_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    word_done = 1'b0;

    if (tvalid_q && M_AXIS_TREADY) tvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 10'd0;
        if (rxs_prev_q && !rxs_q) begin
          state_d = ST_START;
          bit_d   = 3'd0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = 10'd0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = 10'd0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      default: begin
        // Leave at mid stop bit so an immediately following start edge is seen.
        if (cnt_q == DIV_M1) begin
          cnt_d   = 10'd0;
          state_d = ST_IDLE;
          if (rxs_q) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0:    pack_d[7:0]   = shift_q;
              2'd1:    pack_d[15:8]  = shift_q;
              2'd2:    pack_d[23:16] = shift_q;
              default: word_done     = 1'b1;
            endcase
          end else begin
            ferr_d = 1'b1;
            idx_d  = 2'd0;
          end
        end
      end
    endcase

    if (word_done) begin
      if (!tvalid_q || M_AXIS_TREADY) begin
        tdata_d  = {shift_q, pack_q};
        tvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= 10'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      idx_q      <= 2'd0;
      pack_q     <= 24'd0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      pack_q     <= pack_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_rx_axis_master.sv
// Bench for uart_rx_axis_master: table-driven byte frames, hand-written corner
// sequences and randomized frames checked against a byte-packing model.
module tb_uart_rx_axis_master;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        tready = 1'b0;
  logic        tvalid;
  logic [31:0] tdata;
  logic        ferr;
  logic        ovr;
  logic [1:0]  dbg_state;

  uart_rx_axis_master #(.DIV(DIV), .C_M_AXIS_TDATA_WIDTH(32)) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .rxd            (rxd),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TREADY  (tready),
    .frame_err      (ferr),
    .overrun        (ovr),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: run still going at %0t, required completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_tvalid", {31'd0, tvalid}, 32'd1);
        check("hold_tdata", tdata, prev_data);
      end
      if (tvalid && tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got 0x%08h expected no beat at %0t", tdata, $time);
        end else begin
          check("beat_tdata", tdata, exp_q.pop_front());
        end
      end
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
      prev_valid = tvalid;
      prev_ready = tready;
      prev_data  = tdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(DIV);
    end
    rxd = stop_ok;
    tick(DIV);
    rxd = 1'b1;
    tick(gap);
  endtask

  // ---------------- behavioural packing model ----------------
  logic [31:0] m_word = '0;
  int          m_idx = 0;
  int          m_ferr = 0;

  task automatic model_byte(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) begin
      m_ferr++;
      m_idx  = 0;
      m_word = '0;
    end else begin
      m_word = m_word | (32'(b) << (8 * m_idx));
      m_idx++;
      if (m_idx == 4) begin
        exp_q.push_back(m_word);
        m_idx  = 0;
        m_word = '0;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  data;
    logic        stop_ok;
    logic        glitch_before;
    logic        emit;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int hs0, ferr0, ovr0, exp_ferr;
    logic [7:0] b;
    logic       ok;

    tbl[0]  = '{8'hDD, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{8'hCC, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{8'hBB, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{8'hAA, 1'b1, 1'b0, 1'b1, 32'hAABBCCDD};
    tbl[4]  = '{8'h11, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{8'h22, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{8'h33, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{8'h44, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{8'h55, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{8'h66, 1'b1, 1'b0, 1'b1, 32'h66554433};
    tbl[10] = '{8'h78, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[11] = '{8'h56, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{8'h34, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{8'h12, 1'b1, 1'b0, 1'b1, 32'h12345678};

    // Reset values
    rst_n = 1'b0;
    tick(3);
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_frame_err", {31'd0, ferr}, 32'd0);
    check("rst_overrun", {31'd0, ovr}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Table: clean word, frame error mid-word, glitch then clean word
    tready   = 1'b1;
    hs0      = hs_cnt;
    ferr0    = ferr_cnt;
    ovr0     = ovr_cnt;
    exp_ferr = 0;
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].glitch_before) begin
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(30);
      end
      if (tbl[i].emit) exp_q.push_back(tbl[i].word);
      if (!tbl[i].stop_ok) exp_ferr++;
      send_byte(tbl[i].data, tbl[i].stop_ok, DIV);
      if (tbl[i].emit) check("tbl_queue_drained", exp_q.size(), 32'd0);
    end
    tick(2 * DIV);
    check("tbl_beats", hs_cnt - hs0, 32'd3);
    check("tbl_frame_err", ferr_cnt - ferr0, exp_ferr);
    check("tbl_overrun", ovr_cnt - ovr0, 32'd0);

    // Backpressure: second word dropped with a single overrun pulse
    tready = 1'b0;
    hs0    = hs_cnt;
    ovr0   = ovr_cnt;
    ferr0  = ferr_cnt;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, 2);
    tick(10);
    check("bp_tvalid", {31'd0, tvalid}, 32'd1);
    check("bp_tdata", tdata, 32'h04030201);
    check("bp_overrun", ovr_cnt - ovr0, 32'd1);
    check("bp_frame_err", ferr_cnt - ferr0, 32'd0);
    check("bp_no_beat_yet", hs_cnt - hs0, 32'd0);
    exp_q.push_back(32'h04030201);
    tready = 1'b1;
    tick(3);
    check("bp_beats", hs_cnt - hs0, 32'd1);
    check("bp_tvalid_drop", {31'd0, tvalid}, 32'd0);
    check("bp_queue_drained", exp_q.size(), 32'd0);

    // Reset in the middle of the second byte discards the partial word
    send_byte(8'h55, 1'b1, DIV);
    fork
      send_byte(8'hF0, 1'b1, DIV);
      begin
        tick(DIV * 5 + DIV / 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("mid_rst_tdata", tdata, 32'd0);
        check("mid_rst_frame_err", {31'd0, ferr}, 32'd0);
        check("mid_rst_overrun", {31'd0, ovr}, 32'd0);
        check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
        tick(3);
        rst_n = 1'b1;
      end
    join
    hs0 = hs_cnt;
    exp_q.push_back(32'hA3A2A1A0);
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b1, DIV);
    tick(2 * DIV);
    check("post_rst_beats", hs_cnt - hs0, 32'd1);
    check("post_rst_queue", exp_q.size(), 32'd0);

    // Back-to-back frames with no idle time, random bytes
    hs0   = hs_cnt;
    ovr0  = ovr_cnt;
    ferr0 = ferr_cnt;
    m_idx = 0;
    m_word = '0;
    m_ferr = 0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      model_byte(b, 1'b1);
      send_byte(b, 1'b1, 0);
    end
    tick(2 * DIV);
    check("b2b_beats", hs_cnt - hs0, 32'd3);
    check("b2b_queue", exp_q.size(), 32'd0);
    check("b2b_overrun", ovr_cnt - ovr0, 32'd0);
    check("b2b_frame_err", ferr_cnt - ferr0, 32'd0);

    // Random bytes with occasional bad stop bits and random idle gaps
    ovr0  = ovr_cnt;
    ferr0 = ferr_cnt;
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      model_byte(b, ok);
      send_byte(b, ok, ok ? $urandom_range(0, 4) : DIV + $urandom_range(0, 5));
    end
    tick(2 * DIV);
    check("rand_queue", exp_q.size(), 32'd0);
    check("rand_frame_err", ferr_cnt - ferr0, m_ferr);
    check("rand_overrun", ovr_cnt - ovr0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis_master.md
Name: uart_rx_axis_master

Overview:
UART receiver that converts a serial 8N1 line into 32-bit AXI4-Stream words. It is the receive-side counterpart of the team's AXI-Stream-to-UART transmitter. Four consecutive received bytes are packed least-significant byte first and presented on an AXI-Stream master port. It sits between the board RXD pin and the PL stream fabric.

Parameters:
DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 8..1023; counter width 10 bits.
C_M_AXIS_TDATA_WIDTH, 32, stream data width; fixed at 32 and not otherwise supported.

Ports:
M_AXIS_ACLK  input  1  single clock for the whole block.
M_AXIS_ARESETN  input  1  asynchronous active-low reset.
rxd  input  1  UART serial input; asynchronous; idle high.
M_AXIS_TVALID  output  1  output word valid.
M_AXIS_TDATA  output  32  packed word; first received byte in [7:0].
M_AXIS_TREADY  input  1  downstream accepts the word.
frame_err  output  1  one-cycle pulse when a stop bit samples low.
overrun  output  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset asynchronous, active-low. On reset: M_AXIS_TVALID=0, M_AXIS_TDATA=0, frame_err=0, overrun=0, FSM=IDLE, byte index=0, counters=0, synchronizer flops=1.
- rxd passes through a 2-flop synchronizer (preset to 1) before any use. All timing below refers to the synchronized signal rxs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: a 1->0 transition on rxs loads bit counter=0 and goes to START.
  - START: wait DIV/2 cycles (integer divide), then sample rxs. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no flag.
  - DATA: sample rxs every DIV cycles, 8 samples, LSB first, into a shift register. After the 8th sample, go to STOP.
  - STOP: sample after DIV cycles.
    - If 1: the byte is valid. Write it to packing lane [byte_idx*8+:8] and increment byte_idx. Return to IDLE on that same sample, so a back-to-back start bit is caught.
    - If 0: pulse frame_err for 1 cycle, discard the byte, reset byte_idx=0 (the partial word is discarded), and go to IDLE. IDLE only re-arms on a fresh falling edge, so a break condition produces exactly one frame_err.
- Word completion happens when the 4th valid byte is stored (byte_idx wraps 3->0).
  - If M_AXIS_TVALID=0, or M_AXIS_TVALID=1 and M_AXIS_TREADY=1 in the same cycle: load M_AXIS_TDATA with the packed word and set TVALID=1 on the next cycle.
  - Otherwise, pulse overrun for 1 cycle. The held word and TVALID are unchanged and the new word is lost.
- AXI-Stream rules:
  - Once TVALID=1, TDATA is stable until the handshake (TVALID & TREADY on a rising edge). TVALID then drops the following cycle unless a new word loads in the same cycle.
  - TVALID never depends combinationally on TREADY.
  - Output buffering is one word. Byte reception continues regardless of TREADY.
- Latency: from the rxs stop-bit sample of the 4th byte to TVALID high is 1 cycle. From the rxd pin the total is 2 synchronizer cycles plus the bit timing.
- The baud counter reloads on each state entry, so there is no cumulative drift beyond DIV quantization.
- Reset mid-frame: all state clears immediately. The next falling edge after reset deasserts starts a new byte at byte_idx=0.

Test Plan:
1. DIV=16. Reset, then send bytes 0xDD, 0xCC, 0xBB, 0xAA with TREADY=1 -> exactly one TVALID beat, TDATA=32'hAABBCCDD; no frame_err, no overrun.
2. DIV=16, TREADY=0. Send 8 bytes 0x01..0x08 -> TVALID stays high with TDATA=32'h04030201, overrun pulses once after byte 0x08; raising TREADY gives one handshake, then TVALID=0.
3. DIV=16. Send 0x11, then 0x22 with stop bit forced 0, then 0x33, 0x44, 0x55, 0x66 -> one frame_err pulse; output TDATA=32'h66554433.
4. DIV=16. Drive a 3-cycle low glitch on rxd while idle, then a clean 4-byte word 0x12345678 (bytes 0x78, 0x56, 0x34, 0x12) -> glitch ignored, TDATA=32'h12345678, no flags.
5. DIV=16. Assert M_AXIS_ARESETN low during bit 4 of the second byte, release, send 4 bytes 0xA0..0xA3 -> outputs zero during reset; TDATA=32'hA3A2A1A0.
6. DIV=16. Hold TREADY=1 with zero idle between frames for 12 bytes -> 3 words, each handshaked, TVALID never high on 2 consecutive words without an intervening handshake.
